// File: rtl/heap_pkg.sv
// Shared definitions for the heap arbiter: opcodes, null constants, default width
// and the ALLOC/FREE pairing test used when fusion is built in.
package heap_pkg;

   localparam int DATA_SZ_DEF = 16;

   typedef enum logic [1:0] {
      OP_ALLOC = 2'b00,
      OP_FREE  = 2'b01,
      OP_READ  = 2'b10,
      OP_WRITE = 2'b11
   } op_e;

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

   localparam logic [DATA_SZ_DEF-1:0] UNDEF = {DATA_SZ_DEF{1'b0}};
   localparam logic [DATA_SZ_DEF-1:0] NIL   = {DATA_SZ_DEF{1'b0}};

   // True when one head allocates and the other frees, in either order.
   function automatic logic is_fuse_pair(input logic [1:0] op_x, input logic [1:0] op_y);
      is_fuse_pair = ((op_x == OP_ALLOC) && (op_y == OP_FREE)) ||
                     ((op_x == OP_FREE)  && (op_y == OP_ALLOC));
   endfunction

endpackage

// File: rtl/req_fifo.sv
// Per-client request queue: DEPTH entries (power of two) of DW bits, with full/empty flags.
module req_fifo #(
   parameter int DW    = 34,
   parameter int DEPTH = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_full,
   output logic          o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_data    = r_mem[r_rptr[AW-1:0]];

   // Storage and pointer update; the extra pointer bit separates full from empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= {(AW+1){1'b0}};
         r_rptr <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {DW{1'b0}};
         end
      end else begin
         if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
            r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/heap_arb.sv
// Two-client heap allocator front end: request queues, round-robin issue, registered response.
// Define HEAP_ARB_FUSE_EN to issue an ALLOC head and a FREE head together in one cycle.
module heap_arb
   import heap_pkg::*;
#(
   parameter int DATA_SZ    = DATA_SZ_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_a_valid,
   output logic               o_a_ready,
   input  logic [1:0]         i_a_op,
   input  logic [DATA_SZ-1:0] i_a_arg0,
   input  logic [DATA_SZ-1:0] i_a_arg1,
   output logic               o_a_rvalid,
   output logic [DATA_SZ-1:0] o_a_rdata,
   input  logic               i_b_valid,
   output logic               o_b_ready,
   input  logic [1:0]         i_b_op,
   input  logic [DATA_SZ-1:0] i_b_arg0,
   input  logic [DATA_SZ-1:0] i_b_arg1,
   output logic               o_b_rvalid,
   output logic [DATA_SZ-1:0] o_b_rdata,
   output logic               o_alloc,
   output logic [DATA_SZ-1:0] o_data,
   output logic               o_free,
   output logic [DATA_SZ-1:0] o_faddr,
   output logic               o_wr,
   output logic [DATA_SZ-1:0] o_waddr,
   output logic [DATA_SZ-1:0] o_wdata,
   output logic               o_rd,
   output logic [DATA_SZ-1:0] o_raddr,
   input  logic [DATA_SZ-1:0] i_addr,
   input  logic [DATA_SZ-1:0] i_rdata,
   input  logic               i_err,
   output logic               o_err
);
   localparam int EW = 2 + 2 * DATA_SZ;

   logic [EW-1:0]      w_a_entry;
   logic [EW-1:0]      w_b_entry;
   logic               w_a_full;
   logic               w_a_empty;
   logic               w_b_full;
   logic               w_b_empty;
   logic               w_a_push;
   logic               w_b_push;
   logic               w_issue_ok;
   logic               w_a_head;
   logic               w_b_head;
   logic               w_fuse;
   logic               w_a_go;
   logic               w_b_go;
   logic [1:0]         w_a_op;
   logic [1:0]         w_b_op;
   logic [1:0]         w_s_op;
   logic [DATA_SZ-1:0] w_a_arg0;
   logic [DATA_SZ-1:0] w_a_arg1;
   logic [DATA_SZ-1:0] w_b_arg0;
   logic [DATA_SZ-1:0] w_b_arg1;
   logic [DATA_SZ-1:0] w_s_arg0;
   logic [DATA_SZ-1:0] w_s_arg1;
   logic               w_a_rv;
   logic               w_b_rv;

   logic               r_err;
   prio_e              r_prio;
   logic               r_a_rv;
   logic               r_b_rv;
   logic [1:0]         r_a_tag;
   logic [1:0]         r_b_tag;

   // Response word chosen by the op that was issued in the previous cycle.
   function automatic logic [DATA_SZ-1:0] resp_data(input logic [1:0] tag,
                                                    input logic [DATA_SZ-1:0] addr,
                                                    input logic [DATA_SZ-1:0] rdata);
      case (tag)
         OP_ALLOC: resp_data = addr;
         OP_READ:  resp_data = rdata;
         default:  resp_data = DATA_SZ'(UNDEF);
      endcase
   endfunction

   assign o_a_ready = i_rst_n & ~w_a_full & ~r_err;
   assign o_b_ready = i_rst_n & ~w_b_full & ~r_err;
   assign w_a_push  = i_a_valid & o_a_ready;
   assign w_b_push  = i_b_valid & o_b_ready;

   req_fifo #(.DW(EW), .DEPTH(FIFO_DEPTH)) u_fifo_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_a_push),
      .i_pop   (w_a_go),
      .i_data  ({i_a_op, i_a_arg0, i_a_arg1}),
      .o_data  (w_a_entry),
      .o_full  (w_a_full),
      .o_empty (w_a_empty)
   );

   req_fifo #(.DW(EW), .DEPTH(FIFO_DEPTH)) u_fifo_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_b_push),
      .i_pop   (w_b_go),
      .i_data  ({i_b_op, i_b_arg0, i_b_arg1}),
      .o_data  (w_b_entry),
      .o_full  (w_b_full),
      .o_empty (w_b_empty)
   );

   assign w_a_op   = w_a_entry[EW-1 -: 2];
   assign w_a_arg0 = w_a_entry[2*DATA_SZ-1 -: DATA_SZ];
   assign w_a_arg1 = w_a_entry[DATA_SZ-1:0];
   assign w_b_op   = w_b_entry[EW-1 -: 2];
   assign w_b_arg0 = w_b_entry[2*DATA_SZ-1 -: DATA_SZ];
   assign w_b_arg1 = w_b_entry[DATA_SZ-1:0];

   // An error cycle blocks issue immediately, before the halt flag is registered.
   assign w_issue_ok = ~r_err & ~i_err;
   assign w_a_head   = ~w_a_empty & w_issue_ok;
   assign w_b_head   = ~w_b_empty & w_issue_ok;

`ifdef HEAP_ARB_FUSE_EN
   assign w_fuse = w_a_head & w_b_head & is_fuse_pair(w_a_op, w_b_op);
`else
   assign w_fuse = 1'b0;
`endif

   // Grant selection: fused pair, round-robin on contention, else the lone head.
   always_comb begin
      w_a_go = 1'b0;
      w_b_go = 1'b0;
      if (w_fuse) begin
         w_a_go = 1'b1;
         w_b_go = 1'b1;
      end else if (w_a_head && w_b_head) begin
         if (r_prio == PRIO_A) begin
            w_a_go = 1'b1;
         end else begin
            w_b_go = 1'b1;
         end
      end else if (w_a_head) begin
         w_a_go = 1'b1;
      end else if (w_b_head) begin
         w_b_go = 1'b1;
      end else begin
         w_a_go = 1'b0;
      end
   end

   // Head of the single granted client (meaningless while fused or idle).
   always_comb begin
      w_s_op   = w_a_op;
      w_s_arg0 = w_a_arg0;
      w_s_arg1 = w_a_arg1;
      if (w_b_go && !w_a_go) begin
         w_s_op   = w_b_op;
         w_s_arg0 = w_b_arg0;
         w_s_arg1 = w_b_arg1;
      end else begin
         w_s_op   = w_a_op;
      end
   end

   // Allocator port drive; everything not used by this cycle's op stays at zero.
   always_comb begin
      o_alloc = 1'b0;
      o_data  = {DATA_SZ{1'b0}};
      o_free  = 1'b0;
      o_faddr = {DATA_SZ{1'b0}};
      o_wr    = 1'b0;
      o_waddr = {DATA_SZ{1'b0}};
      o_wdata = {DATA_SZ{1'b0}};
      o_rd    = 1'b0;
      o_raddr = {DATA_SZ{1'b0}};
      if (w_fuse) begin
         o_alloc = 1'b1;
         o_free  = 1'b1;
         if (w_a_op == OP_ALLOC) begin
            o_data  = w_a_arg0;
            o_faddr = w_b_arg0;
         end else begin
            o_data  = w_b_arg0;
            o_faddr = w_a_arg0;
         end
      end else if (w_a_go || w_b_go) begin
         case (w_s_op)
            OP_ALLOC: begin
               o_alloc = 1'b1;
               o_data  = w_s_arg0;
            end
            OP_FREE: begin
               o_free  = 1'b1;
               o_faddr = w_s_arg0;
            end
            OP_READ: begin
               o_rd    = 1'b1;
               o_raddr = w_s_arg0;
            end
            OP_WRITE: begin
               o_wr    = 1'b1;
               o_waddr = w_s_arg0;
               o_wdata = w_s_arg1;
            end
            default: o_alloc = 1'b0;
         endcase
      end else begin
         o_alloc = 1'b0;
      end
   end

   // Halt flag, priority pointer and per-client response tags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err   <= 1'b0;
         r_prio  <= PRIO_A;
         r_a_rv  <= 1'b0;
         r_b_rv  <= 1'b0;
         r_a_tag <= 2'b00;
         r_b_tag <= 2'b00;
      end else begin
         r_err   <= r_err | i_err;
         r_a_rv  <= w_a_go;
         r_b_rv  <= w_b_go;
         r_a_tag <= w_a_go ? w_a_op : 2'b00;
         r_b_tag <= w_b_go ? w_b_op : 2'b00;
         if (w_fuse) begin
            r_prio <= r_prio;
         end else if (w_a_go) begin
            r_prio <= PRIO_B;
         end else if (w_b_go) begin
            r_prio <= PRIO_A;
         end else begin
            r_prio <= r_prio;
         end
      end
   end

   // An allocator error in the response cycle swallows that cycle's responses.
   assign w_a_rv     = r_a_rv & ~i_err;
   assign w_b_rv     = r_b_rv & ~i_err;
   assign o_a_rvalid = w_a_rv;
   assign o_b_rvalid = w_b_rv;
   assign o_a_rdata  = w_a_rv ? resp_data(r_a_tag, i_addr, i_rdata) : {DATA_SZ{1'b0}};
   assign o_b_rdata  = w_b_rv ? resp_data(r_b_tag, i_addr, i_rdata) : {DATA_SZ{1'b0}};
   assign o_err      = r_err;

endmodule

// File: tb/tb_heap_arb.sv
// Self-checking bench for heap_arb; expected responses are queued at drive time
// and compared with the responses the monitor collects. Honours HEAP_ARB_FUSE_EN.
module tb_heap_arb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, b_valid;
   logic [1:0]  a_op, b_op;
   logic [15:0] a_arg0, a_arg1, b_arg0, b_arg1;
   logic        o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid;
   logic [15:0] o_a_rdata, o_b_rdata;
   logic        o_alloc, o_free, o_wr, o_rd, o_err;
   logic [15:0] o_data, o_faddr, o_waddr, o_wdata, o_raddr;
   logic [15:0] i_addr, i_rdata, m_raddr;
   logic        i_err;

   int total = 0;
   int bad = 0;
   logic [15:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$], grants[$];

   always #5 clk = ~clk;

   heap_arb dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a_valid(a_valid), .o_a_ready(o_a_ready), .i_a_op(a_op), .i_a_arg0(a_arg0),
      .i_a_arg1(a_arg1), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
      .i_b_valid(b_valid), .o_b_ready(o_b_ready), .i_b_op(b_op), .i_b_arg0(b_arg0),
      .i_b_arg1(b_arg1), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
      .o_alloc(o_alloc), .o_data(o_data), .o_free(o_free), .o_faddr(o_faddr),
      .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_rd(o_rd), .o_raddr(o_raddr),
      .i_addr(i_addr), .i_rdata(i_rdata), .i_err(i_err), .o_err(o_err)
   );

   // Memory model: read data answers the previous cycle's read address.
   always @(posedge clk) m_raddr <= o_rd ? o_raddr : 16'h0000;
   assign i_rdata = m_raddr ^ 16'h5A5A;

   // Response and grant monitor.
   always @(negedge clk) begin
      if (o_a_rvalid) obs_a.push_back(o_a_rdata);
      if (o_b_rvalid) obs_b.push_back(o_b_rdata);
      if (o_rd) grants.push_back(o_raddr);
   end

   task automatic idle_inputs();
      a_valid = 1'b0; b_valid = 1'b0; a_op = 2'b00; b_op = 2'b00;
      a_arg0 = 16'h0000; a_arg1 = 16'h0000; b_arg0 = 16'h0000; b_arg1 = 16'h0000;
      i_err = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete(); grants.delete();
   endtask

   task automatic compare_scoreboard(input string tag);
      logic [15:0] e, o;
      total++;
      if (obs_a.size() != exp_a.size() || obs_b.size() != exp_b.size()) begin
         bad++;
         $display("FAIL %s count: got a=%0d b=%0d want a=%0d b=%0d", tag,
                  obs_a.size(), obs_b.size(), exp_a.size(), exp_b.size());
      end
      while (exp_a.size() > 0 && obs_a.size() > 0) begin
         e = exp_a.pop_front(); o = obs_a.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL %s a_rdata: got %h want %h", tag, o, e); end
      end
      while (exp_b.size() > 0 && obs_b.size() > 0) begin
         e = exp_b.pop_front(); o = obs_b.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL %s b_rdata: got %h want %h", tag, o, e); end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      i_addr = 16'h0000;
      rst_n = 1'b0;
      #2;
      total++;
      if ({o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_err, o_alloc, o_free, o_wr, o_rd} !== 9'h000) begin
         bad++; $display("FAIL reset_outputs: got %b want 000000000",
            {o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_err, o_alloc, o_free, o_wr, o_rd});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({o_a_ready, o_b_ready, o_err} !== 3'b110) begin
         bad++; $display("FAIL post_reset_ready: got %b want 110", {o_a_ready, o_b_ready, o_err});
      end
   endtask

   task automatic test_alloc();
      do_reset();
      @(posedge clk); #1;
      a_valid = 1'b1; a_op = 2'b00; a_arg0 = 16'h8005; i_addr = 16'h5000;
      exp_a.push_back(16'h5000);
      @(posedge clk); #1;
      a_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({o_alloc, o_free, o_rd, o_wr, o_data} !== {4'b1000, 16'h8005}) begin
         bad++; $display("FAIL alloc_issue: got %b %h want 1000 8005", {o_alloc, o_free, o_rd, o_wr}, o_data);
      end
      total++;
      if (o_a_rvalid !== 1'b0) begin bad++; $display("FAIL alloc_early_rvalid: got %b want 0", o_a_rvalid); end
      @(negedge clk);
      total++;
      if ({o_a_rvalid, o_b_rvalid, o_a_rdata} !== {2'b10, 16'h5000}) begin
         bad++; $display("FAIL alloc_resp: got %b %h want 10 5000", {o_a_rvalid, o_b_rvalid}, o_a_rdata);
      end
      @(negedge clk);
      total++;
      if ({o_a_rvalid, o_b_rvalid} !== 2'b00) begin
         bad++; $display("FAIL alloc_pulse: got %b want 00", {o_a_rvalid, o_b_rvalid});
      end
      compare_scoreboard("alloc");
   endtask

   task automatic test_back_to_back();
      int na = 0;
      int nb = 0;
      logic acc_a, acc_b;
      do_reset();
      @(posedge clk); #1;
      for (int c = 0; c < 60 && (na < 8 || nb < 8); c++) begin
         a_valid = (na < 8); a_op = 2'b10; a_arg0 = 16'h1000 + 16'(na);
         b_valid = (nb < 8); b_op = 2'b10; b_arg0 = 16'h2000 + 16'(nb);
         @(negedge clk);
         acc_a = a_valid & o_a_ready;
         acc_b = b_valid & o_b_ready;
         @(posedge clk); #1;
         if (acc_a) begin exp_a.push_back((16'h1000 + 16'(na)) ^ 16'h5A5A); na++; end
         if (acc_b) begin exp_b.push_back((16'h2000 + 16'(nb)) ^ 16'h5A5A); nb++; end
      end
      idle_inputs();
      repeat (8) @(posedge clk);
      @(negedge clk);
      total++;
      if (na != 8 || nb != 8) begin bad++; $display("FAIL b2b_accept: got a=%0d b=%0d want 8 8", na, nb); end
      total++;
      if (grants.size() != 16) begin bad++; $display("FAIL b2b_grants: got %0d want 16", grants.size()); end
      for (int g = 0; g < grants.size(); g++) begin
         total++;
         if (grants[g][13:12] !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL b2b_order[%0d]: got %h want client %s", g, grants[g], (g % 2 == 0) ? "a" : "b");
         end
      end
      compare_scoreboard("b2b");
   endtask

   task automatic test_fuse();
      do_reset();
      @(posedge clk); #1;
      a_valid = 1'b1; a_op = 2'b00; a_arg0 = 16'h0002;
      b_valid = 1'b1; b_op = 2'b01; b_arg0 = 16'h5003;
      i_addr = 16'h5003;
      exp_a.push_back(16'h5003);
      exp_b.push_back(16'h0000);
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
`ifdef HEAP_ARB_FUSE_EN
      total++;
      if ({o_alloc, o_free, o_data, o_faddr} !== {2'b11, 16'h0002, 16'h5003}) begin
         bad++; $display("FAIL fuse_issue: got %b %h %h want 11 0002 5003", {o_alloc, o_free}, o_data, o_faddr);
      end
      @(negedge clk);
      total++;
      if ({o_a_rvalid, o_b_rvalid, o_alloc, o_free} !== 4'b1100) begin
         bad++; $display("FAIL fuse_resp: got %b want 1100", {o_a_rvalid, o_b_rvalid, o_alloc, o_free});
      end
`else
      total++;
      if ({o_alloc, o_free, o_data} !== {2'b10, 16'h0002}) begin
         bad++; $display("FAIL split_issue1: got %b %h want 10 0002", {o_alloc, o_free}, o_data);
      end
      @(negedge clk);
      total++;
      if ({o_alloc, o_free, o_faddr, o_a_rvalid, o_b_rvalid} !== {2'b01, 16'h5003, 2'b10}) begin
         bad++; $display("FAIL split_issue2: got %b %h %b want 01 5003 10",
                         {o_alloc, o_free}, o_faddr, {o_a_rvalid, o_b_rvalid});
      end
      @(negedge clk);
      total++;
      if ({o_alloc, o_free, o_a_rvalid, o_b_rvalid} !== 4'b0001) begin
         bad++; $display("FAIL split_resp_b: got %b want 0001", {o_alloc, o_free, o_a_rvalid, o_b_rvalid});
      end
`endif
      repeat (2) @(negedge clk);
      compare_scoreboard("fuse");
   endtask

   task automatic test_err();
      logic full_seen = 1'b0;
      do_reset();
      @(posedge clk); #1;
      for (int c = 0; c < 20 && !full_seen; c++) begin
         a_valid = 1'b1; a_op = 2'b10; a_arg0 = 16'h1100 + 16'(c);
         b_valid = 1'b1; b_op = 2'b10; b_arg0 = 16'h2100 + 16'(c);
         @(negedge clk);
         if (!o_a_ready) full_seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total++;
      if (!full_seen) begin bad++; $display("FAIL err_fill: got a_ready=1 want a_ready=0"); end
      a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
      i_err = 1'b1;
      @(negedge clk);
      total++;
      if ({o_a_rvalid, o_b_rvalid, o_alloc, o_free, o_wr, o_rd, o_err} !== 7'b0000000) begin
         bad++; $display("FAIL err_cycle: got %b want 0000000",
                         {o_a_rvalid, o_b_rvalid, o_alloc, o_free, o_wr, o_rd, o_err});
      end
      @(posedge clk); #1;
      i_err = 1'b0;
      for (int c = 0; c < 4; c++) begin
         a_valid = 1'b1; b_valid = 1'b1;
         @(negedge clk);
         total++;
         if ({o_err, o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_alloc, o_free, o_wr, o_rd} !== 9'b100000000) begin
            bad++; $display("FAIL err_halt[%0d]: got %b want 100000000", c,
               {o_err, o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_alloc, o_free, o_wr, o_rd});
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_midop();
      int viol = 0;
      do_reset();
      i_addr = 16'h7777;
      @(posedge clk); #1;
      for (int c = 0; c < 6; c++) begin
         a_valid = 1'b1; a_op = 2'b00; a_arg0 = 16'h0040 + 16'(c);
         b_valid = 1'b1; b_op = 2'b11; b_arg0 = 16'h0080 + 16'(c); b_arg1 = 16'hBEEF;
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_err, o_alloc, o_free, o_wr, o_rd,
           o_a_rdata, o_b_rdata, o_data, o_faddr, o_waddr, o_wdata, o_raddr} !== 121'd0) begin
         bad++; $display("FAIL midop_reset: got %b %h %h %h %h %h %h %h want all zero",
            {o_a_ready, o_b_ready, o_a_rvalid, o_b_rvalid, o_err, o_alloc, o_free, o_wr, o_rd},
            o_a_rdata, o_b_rdata, o_data, o_faddr, o_waddr, o_wdata, o_raddr);
      end
      idle_inputs();
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (o_a_rvalid || o_b_rvalid || o_alloc || o_free || o_wr || o_rd) viol++;
      end
      total++;
      if (viol != 0) begin bad++; $display("FAIL midop_release: got %0d active cycles want 0", viol); end
      total++;
      if ({o_a_ready, o_b_ready} !== 2'b11) begin
         bad++; $display("FAIL midop_ready: got %b want 11", {o_a_ready, o_b_ready});
      end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_back_to_back();
      test_fuse();
      test_err();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
